// File: rtl/tvp5147_pkg.sv
// tvp5147_pkg
// Shared definitions for the TVP5147M1 init sequencer: FSM state encoding,
// default I2C addressing / chip-ID constants and the register init table.
// No ports (package).

package tvp5147_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PWR_WAIT,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_IDLE,
    ST_GAP,
    ST_CHECK_ID,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam logic [7:0] DEF_SLAVE_ADDR = 8'hB8;
  localparam logic [7:0] DEF_ID_SUBADDR = 8'h80;
  localparam logic [7:0] DEF_ID_EXPECT  = 8'h51;

  localparam int INIT_TABLE_LEN = 8;
  localparam int ROM_AW         = $clog2(INIT_TABLE_LEN);

  // Each entry is {sub_addr, data}, written in ascending index order.
  localparam logic [15:0] INIT_TABLE [INIT_TABLE_LEN] = '{
    16'h00_00,
    16'h02_00,
    16'h03_6D,
    16'h0D_47,
    16'h33_40,
    16'h34_11,
    16'h36_00,
    16'h08_00
  };

endpackage

// File: rtl/tvp5147_init_rom.sv
// tvp5147_init_rom
// Combinational lookup of one init-table entry.
// Ports:
//   index    in   4  table entry index
//   sub_addr out  8  register sub-address for that entry
//   data     out  8  register data for that entry
// Indices beyond the table return 00/00 so a larger NUM_REGS writes
// harmless zero entries instead of aliasing onto earlier ones.

module tvp5147_init_rom
  import tvp5147_pkg::*;
(
  input  logic [3:0] index,
  output logic [7:0] sub_addr,
  output logic [7:0] data
);

  always_comb begin
    sub_addr = 8'h00;
    data     = 8'h00;
    if (int'(index) < INIT_TABLE_LEN) begin
      {sub_addr, data} = INIT_TABLE[index[ROM_AW-1:0]];
    end
  end

endmodule

// File: rtl/tvp5147_init_sequencer.sv
// tvp5147_init_sequencer
// Programs the TVP5147M1 through the I2C master: waits for decoder power-up,
// writes NUM_REGS table entries, reads back the chip ID and reports the result.
// Ports:
//   clk            in   1  system clock
//   rst            in   1  synchronous active-high reset
//   init_start     in   1  level; starts a sequence from IDLE/DONE/ERROR
//   i2c_start      out  1  one-clock transaction request to the master
//   i2c_rw         out  1  0 = write, 1 = read
//   i2c_slave_addr out  8  constant SLAVE_ADDR
//   i2c_sub_addr   out  8  register sub-address
//   i2c_data_in    out  8  write data (00 during the ID read)
//   i2c_data_out   in   8  read data from the master
//   i2c_busy       in   1  master transaction in progress
//   done           out  1  sequence finished (held)
//   id_ok          out  1  captured ID matched ID_EXPECT
//   id_value       out  8  captured ID byte
//   error          out  1  busy handshake timed out (held)
//   reg_index      out  4  current / last table entry
//
// state      | meaning
// -----------+--------------------------------------------------------
// IDLE       | waiting for init_start after reset
// PWR_WAIT   | decoder power-up delay, PWR_DELAY clocks
// ISSUE      | one-clock i2c_start; command fields latched on entry
// WAIT_BUSY  | waiting for the master to raise busy
// WAIT_IDLE  | waiting for busy to fall; read data captured here
// GAP        | GAP_CYCLES idle clocks between transactions
// CHECK_ID   | compare captured ID with ID_EXPECT
// DONE       | sequence complete, waits for a new init_start
// ERROR      | timeout; reg_index holds the failing entry

module tvp5147_init_sequencer
  import tvp5147_pkg::*;
#(
  parameter logic [7:0] SLAVE_ADDR   = DEF_SLAVE_ADDR,
  parameter int         NUM_REGS     = 8,
  parameter int         PWR_DELAY    = 1000,
  parameter int         GAP_CYCLES   = 16,
  parameter int         BUSY_TIMEOUT = 4096,
  parameter logic [7:0] ID_SUBADDR   = DEF_ID_SUBADDR,
  parameter logic [7:0] ID_EXPECT    = DEF_ID_EXPECT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init_start,
  output logic       i2c_start,
  output logic       i2c_rw,
  output logic [7:0] i2c_slave_addr,
  output logic [7:0] i2c_sub_addr,
  output logic [7:0] i2c_data_in,
  input  logic [7:0] i2c_data_out,
  input  logic       i2c_busy,
  output logic       done,
  output logic       id_ok,
  output logic [7:0] id_value,
  output logic       error,
  output logic [3:0] reg_index
);

  localparam int CNT_MAX_PB = (PWR_DELAY > BUSY_TIMEOUT) ? PWR_DELAY : BUSY_TIMEOUT;
  localparam int CNT_MAX    = (CNT_MAX_PB > GAP_CYCLES) ? CNT_MAX_PB : GAP_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  // Down-counter reload values: terminal count 0 is reached after N clocks.
  localparam logic [CNT_W-1:0] PWR_LOAD  = CNT_W'(PWR_DELAY - 1);
  localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  // Index is one bit wider than the port so NUM_REGS = 16 can be represented
  // as the "all writes done" value.
  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       idx_q, idx_d;
  logic             start_q, start_d;
  logic             rw_q, rw_d;
  logic [7:0]       sub_q, sub_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             done_q, done_d;
  logic             id_ok_q, id_ok_d;
  logic [7:0]       id_val_q, id_val_d;
  logic             err_q, err_d;

  logic [7:0]       rom_sub;
  logic [7:0]       rom_data;
  logic             cnt_tc;

  tvp5147_init_rom u_rom (
    .index    (idx_q[3:0]),
    .sub_addr (rom_sub),
    .data     (rom_data)
  );

  assign cnt_tc = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    start_d  = 1'b0;
    rw_d     = rw_q;
    sub_d    = sub_q;
    wdata_d  = wdata_q;
    done_d   = done_q;
    id_ok_d  = id_ok_q;
    id_val_d = id_val_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (init_start) begin
          done_d  = 1'b0;
          id_ok_d = 1'b0;
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = ST_PWR_WAIT;
        end
      end
      ST_PWR_WAIT: begin
        if (cnt_tc) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (i2c_busy)    state_d = ST_WAIT_IDLE;
        else if (cnt_tc) state_d = ST_ERROR;
      end
      ST_WAIT_IDLE: begin
        if (!i2c_busy) begin
          if (rw_q) begin
            id_val_d = i2c_data_out;
            state_d  = ST_CHECK_ID;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = ST_GAP;
          end
        end else if (cnt_tc) begin
          state_d = ST_ERROR;
        end
      end
      ST_GAP: begin
        if (cnt_tc) state_d = ST_ISSUE;
      end
      ST_CHECK_ID: begin
        id_ok_d = (id_val_q == ID_EXPECT);
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Command fields are latched when entering ISSUE and then held, so they
    // stay stable for the whole master transaction.
    if (state_d == ST_ISSUE) begin
      start_d = 1'b1;
      if (idx_q == LAST_IDX) begin
        rw_d    = 1'b1;
        sub_d   = ID_SUBADDR;
        wdata_d = 8'h00;
      end else begin
        rw_d    = 1'b0;
        sub_d   = rom_sub;
        wdata_d = rom_data;
      end
    end

    if (state_d == ST_ERROR) err_d = 1'b1;

    // Every state entry reloads the shared down-counter.
    if (state_d != state_q) begin
      case (state_d)
        ST_PWR_WAIT:               cnt_d = PWR_LOAD;
        ST_WAIT_BUSY, ST_WAIT_IDLE: cnt_d = BUSY_LOAD;
        ST_GAP:                    cnt_d = GAP_LOAD;
        default:                   cnt_d = '0;
      endcase
    end else if (!cnt_tc) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      start_q  <= 1'b0;
      rw_q     <= 1'b0;
      sub_q    <= 8'h00;
      wdata_q  <= 8'h00;
      done_q   <= 1'b0;
      id_ok_q  <= 1'b0;
      id_val_q <= 8'h00;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      start_q  <= start_d;
      rw_q     <= rw_d;
      sub_q    <= sub_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      id_ok_q  <= id_ok_d;
      id_val_q <= id_val_d;
      err_q    <= err_d;
    end
  end

  assign i2c_start      = start_q;
  assign i2c_rw         = rw_q;
  assign i2c_slave_addr = SLAVE_ADDR;
  assign i2c_sub_addr   = sub_q;
  assign i2c_data_in    = wdata_q;
  assign done           = done_q;
  assign id_ok          = id_ok_q;
  assign id_value       = id_val_q;
  assign error          = err_q;
  assign reg_index      = idx_q[3:0];

endmodule

// File: tb/tb_tvp5147_init_sequencer.sv
// Testbench for tvp5147_init_sequencer: behavioural I2C master model,
// expected-transaction queue and a monitor that checks each i2c_start.

module tb_tvp5147_init_sequencer;

  localparam int PWR_DELAY    = 10;
  localparam int BUSY_TIMEOUT = 64;
  localparam int GAP_CYCLES   = 16;

  typedef struct packed {
    logic       rw;
    logic [7:0] sub;
    logic [7:0] data;
    logic       gap_chk;
  } txn_t;

  logic       clk;
  logic       rst;
  logic       init_start;
  logic       i2c_start;
  logic       i2c_rw;
  logic [7:0] i2c_slave_addr;
  logic [7:0] i2c_sub_addr;
  logic [7:0] i2c_data_in;
  logic [7:0] i2c_data_out;
  logic       i2c_busy;
  logic       done;
  logic       id_ok;
  logic [7:0] id_value;
  logic       error;
  logic [3:0] reg_index;

  logic [7:0] read_value;
  logic       stall_en;
  logic [7:0] stall_sub;

  int   cyc;
  int   fall_cyc;
  int   last_start_cyc;
  int   errors;
  int   checks;
  txn_t exp_q[$];

  logic [15:0] exp_table [8] = '{16'h0000, 16'h0200, 16'h036D, 16'h0D47,
                                 16'h3340, 16'h3411, 16'h3600, 16'h0800};

  tvp5147_init_sequencer #(
    .PWR_DELAY    (PWR_DELAY),
    .BUSY_TIMEOUT (BUSY_TIMEOUT),
    .GAP_CYCLES   (GAP_CYCLES)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .init_start     (init_start),
    .i2c_start      (i2c_start),
    .i2c_rw         (i2c_rw),
    .i2c_slave_addr (i2c_slave_addr),
    .i2c_sub_addr   (i2c_sub_addr),
    .i2c_data_in    (i2c_data_in),
    .i2c_data_out   (i2c_data_out),
    .i2c_busy       (i2c_busy),
    .done           (done),
    .id_ok          (id_ok),
    .id_value       (id_value),
    .error          (error),
    .reg_index      (reg_index)
  );

  assign i2c_data_out = read_value;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Master model: busy rises 2 clocks after i2c_start, falls 40 clocks later.
  initial begin
    i2c_busy = 1'b0;
    fall_cyc = 0;
    forever begin
      @(negedge clk);
      if (i2c_start && !(stall_en && i2c_sub_addr == stall_sub)) begin
        repeat (2) @(negedge clk);
        i2c_busy = 1'b1;
        repeat (40) @(negedge clk);
        i2c_busy = 1'b0;
        fall_cyc = cyc;
      end
    end
  end

  // Monitor: every i2c_start pops one expected transaction.
  initial begin
    txn_t t;
    bit width_pending;
    width_pending = 1'b0;
    last_start_cyc = 0;
    forever begin
      @(negedge clk);
      if (width_pending) begin
        chk("start_width", {31'b0, i2c_start}, 32'd0);
        width_pending = 1'b0;
      end else if (i2c_start) begin
        last_start_cyc = cyc;
        width_pending  = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: got start sub=%0h expected none (cycle %0d)",
                   i2c_sub_addr, cyc);
        end else begin
          t = exp_q.pop_front();
          chk("txn_rw", {31'b0, i2c_rw}, {31'b0, t.rw});
          chk("txn_sub", {24'b0, i2c_sub_addr}, {24'b0, t.sub});
          chk("txn_data", {24'b0, i2c_data_in}, {24'b0, t.data});
          chk("txn_slave", {24'b0, i2c_slave_addr}, 32'hB8);
          if (t.gap_chk) chk("gap_spacing", cyc - fall_cyc, GAP_CYCLES + 1);
        end
      end
    end
  end

  task automatic push_writes(input int n);
    txn_t t;
    for (int i = 0; i < n; i++) begin
      t.rw      = 1'b0;
      t.sub     = exp_table[i][15:8];
      t.data    = exp_table[i][7:0];
      t.gap_chk = (i > 0);
      exp_q.push_back(t);
    end
  endtask

  task automatic push_full_seq();
    txn_t t;
    push_writes(8);
    t.rw      = 1'b1;
    t.sub     = 8'h80;
    t.data    = 8'h00;
    t.gap_chk = 1'b1;
    exp_q.push_back(t);
  endtask

  task automatic pulse_start();
    init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
  endtask

  task automatic pulse_and_latency();
    int c0;
    int n;
    c0 = cyc;
    pulse_start();
    n = 0;
    while (!i2c_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("pwr_latency", cyc - c0, PWR_DELAY + 1);
  endtask

  task automatic wait_done(input int maxc);
    int n;
    n = 0;
    while (!done && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_done: got no done expected done within %0d cycles", maxc);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_start"}, {31'b0, i2c_start}, 32'd0);
    chk({tag, "_rw"}, {31'b0, i2c_rw}, 32'd0);
    chk({tag, "_sub"}, {24'b0, i2c_sub_addr}, 32'd0);
    chk({tag, "_data"}, {24'b0, i2c_data_in}, 32'd0);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_id_ok"}, {31'b0, id_ok}, 32'd0);
    chk({tag, "_id_value"}, {24'b0, id_value}, 32'd0);
    chk({tag, "_error"}, {31'b0, error}, 32'd0);
    chk({tag, "_reg_index"}, {28'b0, reg_index}, 32'd0);
    chk({tag, "_slave"}, {24'b0, i2c_slave_addr}, 32'hB8);
  endtask

  task automatic check_result(input string tag, input logic exp_ok, input logic [7:0] exp_id);
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
    chk({tag, "_id_ok"}, {31'b0, id_ok}, {31'b0, exp_ok});
    chk({tag, "_id_value"}, {24'b0, id_value}, {24'b0, exp_id});
    chk({tag, "_error"}, {31'b0, error}, 32'd0);
    chk({tag, "_reg_index"}, {28'b0, reg_index}, 32'd8);
    chk({tag, "_queue_empty"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    int n;
    errors     = 0;
    checks     = 0;
    rst        = 1'b1;
    init_start = 1'b0;
    stall_en   = 1'b0;
    stall_sub  = 8'h03;
    read_value = 8'h51;

    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Full sequence, matching ID.
    push_full_seq();
    pulse_and_latency();
    wait_done(2000);
    check_result("seq_id51", 1'b1, 8'h51);

    // Full sequence, mismatching ID.
    read_value = 8'h47;
    push_full_seq();
    pulse_start();
    wait_done(2000);
    check_result("seq_id47", 1'b0, 8'h47);

    // Third transaction never gets busy: timeout into ERROR.
    stall_en = 1'b1;
    push_writes(3);
    pulse_start();
    n = 0;
    while (!error && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("err_latency", cyc - last_start_cyc, BUSY_TIMEOUT + 1);
    chk("err_flag", {31'b0, error}, 32'd1);
    chk("err_reg_index", {28'b0, reg_index}, 32'd2);
    chk("err_done", {31'b0, done}, 32'd0);
    repeat (200) @(negedge clk);
    chk("err_held", {31'b0, error}, 32'd1);
    chk("err_queue_empty", exp_q.size(), 32'd0);
    stall_en = 1'b0;

    // Reset while waiting for busy to fall on entry 4.
    read_value = 8'h51;
    push_writes(5);
    pulse_start();
    n = 0;
    while (!(i2c_sub_addr == 8'h33 && i2c_busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("entry4_reached", {24'b0, i2c_sub_addr}, 32'h33);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("midrst_queue_empty", exp_q.size(), 32'd0);
    chk("midrst_idle_done", {31'b0, done}, 32'd0);

    // Restart after reset runs from entry 0.
    push_full_seq();
    pulse_and_latency();
    wait_done(2000);
    check_result("restart", 1'b1, 8'h51);

    // init_start held high: one sequence, then immediate restart after done.
    push_full_seq();
    init_start = 1'b1;
    @(negedge clk);
    chk("held_restart_done_clr", {31'b0, done}, 32'd0);
    wait_done(2000);
    check_result("held", 1'b1, 8'h51);
    @(negedge clk);
    chk("held_next_done", {31'b0, done}, 32'd0);
    chk("held_next_reg_index", {28'b0, reg_index}, 32'd0);
    init_start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got time limit expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tvp5147_init_sequencer.md
Name: tvp5147_init_sequencer

Overview:
- Drives the TVP5147M1 register-programming flow through the existing i2c_master_controller, connecting directly to its start/rw/slave_addr/sub_addr/data_in/data_out/busy pins.
- Waits for decoder power-up, then writes a fixed table of sub-address/data pairs in order.
- Reads back the chip-ID register and reports done, id_ok or error to the capture pipeline.

Parameters:
- SLAVE_ADDR, 8'hB8, 8-bit I2C address byte presented on i2c_slave_addr.
- NUM_REGS, 8, number of table entries written (1..16).
- PWR_DELAY, 1000, clocks waited after init_start before the first transaction (at least 1).
- GAP_CYCLES, 16, idle clocks between consecutive transactions (at least 1).
- BUSY_TIMEOUT, 4096, maximum clocks spent in WAIT_BUSY or WAIT_IDLE before error.
- ID_SUBADDR, 8'h80, sub-address read for the ID check.
- ID_EXPECT, 8'h51, expected ID byte.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- init_start  in  1  level; sampled each clock, starts a sequence from IDLE/DONE/ERROR
- i2c_start  out  1  one-clock pulse to the master
- i2c_rw  out  1  0 = write, 1 = read
- i2c_slave_addr  out  8  always SLAVE_ADDR
- i2c_sub_addr  out  8  register sub-address
- i2c_data_in  out  8  write data; 8'h00 during reads
- i2c_data_out  in  8  read data from the master
- i2c_busy  in  1  master transaction in progress
- done  out  1  sequence finished (level, held)
- id_ok  out  1  captured ID equals ID_EXPECT (valid when done=1)
- id_value  out  8  captured ID byte
- error  out  1  timeout occurred (level, held)
- reg_index  out  4  index of the current/last table entry

Behaviour:
- Reset values, applied at the first clk edge with rst=1, including mid-operation:
  - i2c_start=0, i2c_rw=0, i2c_sub_addr=0, i2c_data_in=0, done=0, id_ok=0, id_value=0, error=0, reg_index=0.
  - State returns to IDLE; all counters clear.
- i2c_slave_addr is a constant SLAVE_ADDR.
- States: IDLE, PWR_WAIT, ISSUE, WAIT_BUSY, WAIT_IDLE, GAP, CHECK_ID, DONE, ERROR.
- IDLE, DONE, ERROR: init_start=1 clears done/id_ok/error/reg_index and enters PWR_WAIT. init_start is ignored in every other state.
- PWR_WAIT: counts PWR_DELAY clocks, then enters ISSUE.
- ISSUE, lasting one clock:
  - Drive i2c_sub_addr/i2c_data_in from table[reg_index] with rw=0, or from ID_SUBADDR with rw=1 and data 0 in the ID phase.
  - i2c_start=1 for exactly this clock; go to WAIT_BUSY.
  - Address, data and rw stay stable from ISSUE until leaving WAIT_IDLE.
- WAIT_BUSY: on i2c_busy=1 go to WAIT_IDLE; after BUSY_TIMEOUT clocks go to ERROR.
- WAIT_IDLE: on i2c_busy=0:
  - Write phase: increment reg_index and go to GAP.
  - ID phase: capture i2c_data_out into id_value on that same edge and go to CHECK_ID.
  - After BUSY_TIMEOUT clocks without busy falling: go to ERROR.
- GAP: waits GAP_CYCLES clocks, then:
  - reg_index < NUM_REGS: ISSUE, write phase.
  - reg_index = NUM_REGS: ISSUE, ID phase. reg_index holds at NUM_REGS.
- CHECK_ID: id_ok <= (id_value == ID_EXPECT); next state DONE with done=1.
- ERROR: error=1; reg_index holds the failing entry.
- Busy already high in ISSUE (master stuck): there is no special case. WAIT_BUSY sees busy=1 immediately and WAIT_IDLE's timeout covers the hang.
- Timeout counter resets on every state entry.
- Total writes issued = NUM_REGS, always in ascending index order. No retries.

Decomposition:
- Package tvp5147_pkg: state encoding; the init table as a constant array of {sub_addr, data} pairs:
  - (00,00) (02,00) (03,6D) (0D,47) (33,40) (34,11) (36,00) (08,00)
- Package tvp5147_pkg also holds default SLAVE_ADDR, ID_SUBADDR and ID_EXPECT.
- One sub-module, tvp5147_init_rom: combinational index to {sub_addr, data} lookup over the package table.

Test Plan:
- Bench setup: behavioural master model raises busy 2 clocks after i2c_start and drops it 40 clocks later; returns 8'h51 on reads; PWR_DELAY=10. Stimulus: init_start=1 for one clock. Required response:
  - 8 write pulses with (sub_addr,data) = table order (00,00)…(08,00), rw=0, slave_addr=B8.
  - Then one read at sub_addr 80.
  - done=1, id_ok=1, id_value=51, error=0, reg_index=8.
- Same run with the model returning 8'h47: done=1, id_ok=0, id_value=47.
- Model never raises busy on the 3rd transaction, BUSY_TIMEOUT=64: error=1 exactly 64 clocks after entering WAIT_BUSY, reg_index=2, done=0, no further i2c_start.
- rst asserted while WAIT_IDLE on entry 4: next edge all outputs are 0 and state is IDLE. A following init_start restarts from entry 0 after PWR_DELAY.
- init_start held high throughout: exactly one sequence runs. After done=1 the next clock restarts it (done clears, reg_index=0).
- Timing check: i2c_start is high for exactly 1 clock per transaction. Spacing from busy falling to the next i2c_start is GAP_CYCLES+1 clocks (17 at default).
